// File: rtl/cdb_buffer.sv
// cdb_buffer: in-order completion FIFO between FU results and the CDB.
// Optional same-cycle FU->CDB bypass when CDB_BYPASS_EN is defined.
`ifndef WAY
`define WAY 3
`endif
`ifndef PHY_REG_SIZE
`define PHY_REG_SIZE 64
`endif

package cdb_pkg;
  localparam int TAG_W = 8;
  localparam int ROB_W = $clog2(`PHY_REG_SIZE - 32);
  typedef logic [TAG_W-1:0] phy_reg_tag_t;
  typedef logic [ROB_W-1:0] rob_idx_t;
  typedef struct packed {
    logic         valid;
    phy_reg_tag_t phy;
  } cdb_tag_t;
  typedef struct packed {
    cdb_tag_t tag;
  } complete_packet_t;
endpackage

module cdb_buffer
  import cdb_pkg::*;
#(
  parameter int IN_WIDTH = 4,
  parameter int C_WIDTH  = `WAY,
  parameter int DEPTH    = 8,
  parameter int ROB_SIZE = `PHY_REG_SIZE - 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [IN_WIDTH-1:0]           fu_valid,
  input  phy_reg_tag_t [IN_WIDTH-1:0]   fu_tag,
  input  rob_idx_t [IN_WIDTH-1:0]       fu_rob_index,
  output logic [IN_WIDTH-1:0]           fu_stall,
  input  rob_idx_t                      rob_head,
  input  logic                          rewind_valid,
  input  rob_idx_t                      rewind_rob_index,
  output complete_packet_t [C_WIDTH-1:0] complete,
  output rob_idx_t [C_WIDTH-1:0]        complete_rob_index,
  output logic [$clog2(DEPTH+1)-1:0]    occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [OCC_W-1:0] occ_q;
  phy_reg_tag_t     tag_q [DEPTH];
  rob_idx_t         rob_q [DEPTH];
  logic [DEPTH-1:0] live_q;

  logic [IN_WIDTH-1:0] acc;
  logic [DEPTH-1:0]    wr_en;
  logic [DEPTH-1:0]    wr_live;
  phy_reg_tag_t        wr_tag [DEPTH];
  rob_idx_t            wr_rob [DEPTH];
  int                  n_push;
  int                  n_pop;
  int                  n_byp;

  function automatic int age(input rob_idx_t x, input rob_idx_t h);
    int d;
    d = int'(x) - int'(h);
    if (d < 0) d = d + ROB_SIZE;
    return d;
  endfunction

  function automatic logic younger(input rob_idx_t x,
                                   input rob_idx_t h,
                                   input rob_idx_t r,
                                   input logic     v);
    return v && (age(x, h) > age(r, h));
  endfunction

  assign occupancy = occ_q;

  // Backpressure from the registered count only; accept from port 0 up.
  always_comb begin
    fu_stall = '0;
    for (int i = 0; i < IN_WIDTH; i++)
      fu_stall[i] = (i >= DEPTH - int'(occ_q));
    acc = fu_valid & ~fu_stall;
  end

  // Broadcast stored entries, route accepted results to CDB or FIFO.
  always_comb begin
    logic [PTR_W-1:0] slot;
    int               k;
    slot    = '0;
    k       = 0;
    wr_en   = '0;
    wr_live = '0;
    for (int e = 0; e < DEPTH; e++) begin
      wr_tag[e] = '0;
      wr_rob[e] = '0;
    end
    complete           = '0;
    complete_rob_index = '0;
    n_push = 0;
    n_byp  = 0;
    n_pop  = (int'(occ_q) < C_WIDTH) ? int'(occ_q) : C_WIDTH;
    for (int s = 0; s < C_WIDTH; s++) begin
      if (s < int'(occ_q)) begin
        slot = PTR_W'(int'(head_q) + s);
        complete[s].tag.phy   = tag_q[slot];
        complete[s].tag.valid = live_q[slot] &&
          !younger(rob_q[slot], rob_head,
                   rewind_rob_index, rewind_valid);
        complete_rob_index[s] = rob_q[slot];
      end
    end
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (acc[i]) begin
`ifdef CDB_BYPASS_EN
        if (reset && (int'(occ_q) + n_byp < C_WIDTH)) begin
          k = int'(occ_q) + n_byp;
          complete[k].tag.phy   = fu_tag[i];
          complete[k].tag.valid = !younger(fu_rob_index[i], rob_head,
                                           rewind_rob_index, rewind_valid);
          complete_rob_index[k] = fu_rob_index[i];
          n_byp = n_byp + 1;
        end else
`endif
        begin
          slot = PTR_W'(int'(tail_q) + n_push);
          wr_en[slot]   = 1'b1;
          wr_tag[slot]  = fu_tag[i];
          wr_rob[slot]  = fu_rob_index[i];
          wr_live[slot] = !younger(fu_rob_index[i], rob_head,
                                   rewind_rob_index, rewind_valid);
          n_push = n_push + 1;
        end
      end
    end
  end

  // Pointer/count update, entry writes and rewind squash of live bits.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      live_q <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        tag_q[e] <= '0;
        rob_q[e] <= '0;
      end
    end else begin
      head_q <= PTR_W'(int'(head_q) + n_pop);
      tail_q <= PTR_W'(int'(tail_q) + n_push);
      occ_q  <= OCC_W'(int'(occ_q) + n_push - n_pop);
      for (int e = 0; e < DEPTH; e++) begin
        if (wr_en[e]) begin
          tag_q[e]  <= wr_tag[e];
          rob_q[e]  <= wr_rob[e];
          live_q[e] <= wr_live[e];
        end else if (younger(rob_q[e], rob_head,
                             rewind_rob_index, rewind_valid)) begin
          live_q[e] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_buffer.sv
// tb_cdb_buffer: directed plus random stimulus against a queue model
// of the completion buffer.
module tb_cdb_buffer;
  import cdb_pkg::*;

  localparam int IW = 4;
  localparam int CW = 3;
  localparam int DP = 8;
  localparam int RS = 32;

  typedef struct {
    logic [7:0] tag;
    logic [4:0] rob;
    bit         live;
  } ent_t;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [IW-1:0]          fu_valid = '0;
  phy_reg_tag_t [IW-1:0]  fu_tag = '0;
  rob_idx_t [IW-1:0]      fu_rob_index = '0;
  logic [IW-1:0]          fu_stall;
  rob_idx_t               rob_head = '0;
  logic                   rewind_valid = 1'b0;
  rob_idx_t               rewind_rob_index = '0;
  complete_packet_t [CW-1:0] complete;
  rob_idx_t [CW-1:0]      complete_rob_index;
  logic [3:0]             occupancy;

  int   ncmp = 0;
  int   nerr = 0;
  ent_t q[$];

  cdb_buffer #(
    .IN_WIDTH(IW),
    .C_WIDTH(CW),
    .DEPTH(DP),
    .ROB_SIZE(RS)
  ) dut (
    .clock(clk),
    .reset(rst_n),
    .fu_valid(fu_valid),
    .fu_tag(fu_tag),
    .fu_rob_index(fu_rob_index),
    .fu_stall(fu_stall),
    .rob_head(rob_head),
    .rewind_valid(rewind_valid),
    .rewind_rob_index(rewind_rob_index),
    .complete(complete),
    .complete_rob_index(complete_rob_index),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  function automatic int age(input int x);
    return (((x - int'(rob_head)) % RS) + RS) % RS;
  endfunction

  function automatic bit yng(input int x);
    return rewind_valid && (age(x) > age(int'(rewind_rob_index)));
  endfunction

  // Called at posedge+1 with inputs already driven.
  task automatic step();
    ent_t       acc[$];
    ent_t       e;
    int         occ;
    int         npop;
    int         j;
    logic [IW-1:0] es;
    logic       ev;
    logic [7:0] et;
    logic [4:0] er;
    #4;
    occ = q.size();
    es = '0;
    for (int i = 0; i < IW; i++)
      es[i] = (i >= DP - occ);
    for (int i = 0; i < IW; i++) begin
      if (rst_n && fu_valid[i] && !es[i]) begin
        e.tag  = fu_tag[i];
        e.rob  = fu_rob_index[i];
        e.live = !yng(int'(fu_rob_index[i]));
        acc.push_back(e);
      end
    end
    j = 0;
    for (int k = 0; k < CW; k++) begin
      ev = 1'b0;
      et = '0;
      er = '0;
      if (k < occ) begin
        ev = q[k].live && !yng(int'(q[k].rob));
        et = q[k].tag;
        er = q[k].rob;
      end
`ifdef CDB_BYPASS_EN
      else if (j < acc.size()) begin
        ev = acc[j].live;
        et = acc[j].tag;
        er = acc[j].rob;
        j++;
      end
`endif
      chk($sformatf("valid[%0d]", k), 32'(complete[k].tag.valid), 32'(ev));
      chk($sformatf("tag[%0d]", k), 32'(complete[k].tag.phy), 32'(et));
      chk($sformatf("rob[%0d]", k), 32'(complete_rob_index[k]), 32'(er));
    end
    chk("fu_stall", 32'(fu_stall), 32'(es));
    chk("occupancy", 32'(occupancy), 32'(occ));
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
    end else begin
      npop = (occ < CW) ? occ : CW;
      repeat (npop) void'(q.pop_front());
      foreach (q[n])
        if (yng(int'(q[n].rob))) q[n].live = 1'b0;
      for (int n = j; n < acc.size(); n++)
        q.push_back(acc[n]);
    end
    #1;
  endtask

  task automatic put(input int i, input logic [7:0] t,
                     input logic [4:0] r);
    fu_valid[i]     = 1'b1;
    fu_tag[i]       = t;
    fu_rob_index[i] = r;
  endtask

  task automatic idle();
    fu_valid     = '0;
    rewind_valid = 1'b0;
  endtask

  initial begin
    // Reset held with FU ports active.
    for (int i = 0; i < IW; i++) put(i, 8'(8'h10 + i), 5'(i));
    step();
    rst_n = 1'b1;
    idle();
    // Single result.
    put(0, 8'h40, 5'd3);
    step();
    idle();
    step();
    // Four per cycle for several cycles, then drain.
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < IW; i++)
        put(i, 8'(8'h41 + i + 4 * c), 5'(i + 4 * c));
      step();
    end
    idle();
    repeat (3) step();
    // Wrap-around age check with rob_head 30.
    rob_head = 5'd30;
    put(0, 8'h50, 5'd31);
    put(1, 8'h51, 5'd0);
    put(2, 8'h52, 5'd2);
    step();
    idle();
    rewind_valid     = 1'b1;
    rewind_rob_index = 5'd0;
    step();
    idle();
    step();
    // Rewind coinciding with incoming younger/older results.
    rewind_valid     = 1'b1;
    rewind_rob_index = 5'd0;
    put(0, 8'h60, 5'd5);
    put(1, 8'h61, 5'd31);
    step();
    idle();
    repeat (2) step();
    // Build up entries then assert reset mid-cycle.
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < IW; i++)
        put(i, 8'(8'h70 + i + 4 * c), 5'(i + 4 * c));
      step();
    end
    idle();
    rst_n = 1'b0;
    #1;
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_cmp", 32'(complete), 32'd0);
    chk("rst_rob", 32'(complete_rob_index), 32'd0);
    chk("rst_stall", 32'(fu_stall), 32'd0);
    q.delete();
    step();
    rst_n = 1'b1;
    repeat (2) step();
    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      fu_valid = 4'($urandom);
      for (int i = 0; i < IW; i++) begin
        fu_tag[i]       = 8'($urandom);
        fu_rob_index[i] = 5'($urandom);
      end
      if (c % 50 == 0) rob_head = 5'($urandom);
      rewind_valid     = ($urandom_range(0, 5) == 0);
      rewind_rob_index = 5'($urandom);
      step();
    end
    idle();
    repeat (4) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
